instr_prefetch_unit: RTL and testbench

- Fetch stage upstream of the 8-bit CPU core.
- Reads 16-bit instructions from a byte-wide program memory: high byte at byte address 2*pc, low byte at 2*pc+1.
- Assembles the two bytes and buffers complete instructions in a small FIFO.
- Presents instructions to the core over a valid/ready handshake; flushes and re-steers on a jump redirect.

---
 rtl/instr_prefetch_unit.sv | 116 +++++++++++
 tb/tb_instr_prefetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch: reads hi/lo bytes from program memory and queues assembled 16-bit
// instructions in a FIFO. Defining PREFETCH_STATS_EN adds a saturating redirect counter (flush_count).
module instr_prefetch_unit #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        mem_req,
  output logic [8:0]  mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr_data,
  output logic [7:0]  instr_pc,
  input  logic        instr_ready
`ifdef PREFETCH_STATS_EN
  ,
  output logic [7:0]  flush_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned OW = 2;

  logic [8:0]    fetch_addr;
  logic [7:0]    hi_byte;
  logic          resp_lo;
  logic [7:0]    resp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard_cnt;
  logic [CW-1:0] reserved;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   fifo_data [DEPTH];
  logic [7:0]    fifo_pc   [DEPTH];

  logic issue_lo, room, grant, take, push, pop;

  // Even byte addresses are always hi bytes, so the issue phase is the address LSB.
  always_comb begin
    issue_lo = fetch_addr[0];
    room     = (SW'(count) + SW'(reserved)) < SW'(DEPTH);
    mem_req  = !reset && !redirect_valid && (outstanding < OW'(MAX_OUTSTANDING)) && (issue_lo || room);
    grant    = mem_req && mem_gnt;
    take     = mem_rvalid && !redirect_valid && (discard_cnt == '0);
    push     = take && resp_lo;
    pop      = instr_valid && instr_ready && !redirect_valid;
  end

  assign mem_addr    = fetch_addr;
  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? fifo_data[rd_ptr] : 16'h0000;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : 8'h00;

  // Control state; a redirect flushes everything and marks in-flight reads for discard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_addr  <= '0;
      hi_byte     <= '0;
      resp_lo     <= 1'b0;
      resp_pc     <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      reserved    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect_valid) begin
      fetch_addr  <= {redirect_pc, 1'b0};
      resp_lo     <= 1'b0;
      resp_pc     <= redirect_pc;
      outstanding <= outstanding - OW'(mem_rvalid);
      discard_cnt <= outstanding - OW'(mem_rvalid);
      reserved    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (grant) fetch_addr <= fetch_addr + 9'd1;
      outstanding <= outstanding + OW'(grant) - OW'(mem_rvalid);
      if (mem_rvalid && (discard_cnt != '0)) discard_cnt <= discard_cnt - OW'(1);
      if (take && !resp_lo) hi_byte <= mem_rdata;
      if (take) resp_lo <= !resp_lo;
      if (push) begin
        resp_pc <= resp_pc + 8'd1;
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      reserved <= reserved + CW'(grant && !issue_lo) - CW'(push);
      count    <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the read side is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= {hi_byte, mem_rdata};
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flush_count <= '0;
    else if (redirect_valid && (flush_count != 8'hFF)) flush_count <= flush_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: a cycle table for streaming, directed corner sequences,
// then random traffic checked against a stream-level model of fetch and delivery order.
module tb_instr_prefetch_unit;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        mem_req;
  logic [8:0]  mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [7:0]  instr_pc;
  logic        instr_ready = 1'b0;
`ifdef PREFETCH_STATS_EN
  logic [7:0]  flush_count;
`endif

  instr_prefetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
`ifdef PREFETCH_STATS_EN
    , .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] addr; int due; } rd_t;
  typedef struct {
    bit gnt; bit rvalid; logic [7:0] rdata; bit ready;
    bit req; logic [8:0] addr; bit iv; logic [15:0] id; logic [7:0] ipc;
  } vec_t;

  logic [7:0]  prog [512];
  rd_t         pend [$];
  logic [7:0]  acc_pc [$];
  int          cyc = 0;
  int          grants = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_pc = 8'h00;
  logic [8:0]  exp_fetch = 9'h000;
  bit          prev_req = 1'b0, prev_gnt = 1'b0;
  logic [8:0]  prev_addr = 9'h000;
  logic        s_req, s_iv;
  logic [8:0]  s_addr;
  logic [15:0] s_id;
  logic [7:0]  s_ipc;
  int unsigned obs_out = 0;
  vec_t        tbl [8];

  // Reads returned with nothing in flight would be a broken memory model.
  always @(posedge clk or posedge reset) begin
    if (reset) obs_out <= 0;
    else begin
      assert (!(mem_rvalid && obs_out == 0)) else $error("FAIL illegal_rvalid: rvalid with 0 outstanding");
      obs_out <= obs_out + ((mem_req && mem_gnt) ? 1 : 0) - (mem_rvalid ? 1 : 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample();
    s_req = mem_req; s_addr = mem_addr; s_iv = instr_valid; s_id = instr_data; s_ipc = instr_pc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h00;
    redirect_valid = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
    pend.delete(); acc_pc.delete();
    exp_pc = 8'h00; exp_fetch = 9'h000; prev_req = 1'b0; grants = 0;
    @(posedge clk); #1;
    sample();
    check("rst_req", 32'(s_req), 0);
    check("rst_addr", 32'(s_addr), 0);
    check("rst_valid", 32'(s_iv), 0);
    check("rst_data", 32'(s_id), 0);
    check("rst_pc", 32'(s_ipc), 0);
`ifdef PREFETCH_STATS_EN
    check("rst_flush_count", 32'(flush_count), 0);
`endif
    #1 reset = 1'b0;
  endtask

  // One clock of traffic: memory model drives responses, model checks grants and deliveries.
  task automatic cycle(input bit gnt, input bit rdy, input bit redir, input logic [7:0] rpc,
                       input int lat_lo, input int lat_hi);
    bit rv;
    logic [7:0] rd;
    @(negedge clk);
    rv = 1'b0; rd = 8'($urandom);
    if (pend.size() > 0 && pend[0].due <= cyc) begin rv = 1'b1; rd = prog[pend[0].addr]; end
    mem_gnt = gnt; instr_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    mem_rvalid = rv; mem_rdata = rd;
    #1;
    sample();
    if (!s_iv) begin
      check("empty_data", 32'(s_id), 0);
      check("empty_pc", 32'(s_ipc), 0);
    end
    if (redir) check("req_in_redirect", 32'(s_req), 0);
    else if (prev_req && !prev_gnt) begin
      check("stall_req", 32'(s_req), 1);
      check("stall_addr", 32'(s_addr), 32'(prev_addr));
    end
    if (s_req && gnt) begin
      check("grant_addr", 32'(s_addr), 32'(exp_fetch));
      exp_fetch = exp_fetch + 9'd1;
      grants++;
    end
    if (redir) begin
      exp_pc = rpc; exp_fetch = {rpc, 1'b0};
    end else if (s_iv && rdy) begin
      check("instr_pc", 32'(s_ipc), 32'(exp_pc));
      check("instr_data", 32'(s_id), 32'({prog[{exp_pc, 1'b0}], prog[{exp_pc, 1'b1}]}));
      acc_pc.push_back(s_ipc);
      exp_pc = exp_pc + 8'd1;
    end
    prev_req = s_req && !redir; prev_gnt = gnt; prev_addr = s_addr;
    @(posedge clk);
    cyc++;
    if (rv) void'(pend.pop_front());
    if (s_req && gnt) begin
      pend.push_back('{s_addr, cyc + int'($urandom_range(lat_lo, lat_hi)) - 1});
      check("outstanding_limit", 32'(pend.size() <= MAX_OUT), 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) prog[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) prog[i] = 8'((i + 1) * 16);

    // Streaming with 1-cycle read latency: first instruction visible in cycle 3.
    tbl[0] = '{1, 0, 8'h00, 1, 1, 9'h000, 0, 16'h0000, 8'h00};
    tbl[1] = '{1, 1, 8'h10, 1, 1, 9'h001, 0, 16'h0000, 8'h00};
    tbl[2] = '{1, 1, 8'h20, 1, 1, 9'h002, 0, 16'h0000, 8'h00};
    tbl[3] = '{1, 1, 8'h30, 1, 1, 9'h003, 1, 16'h1020, 8'h00};
    tbl[4] = '{1, 1, 8'h40, 1, 1, 9'h004, 0, 16'h0000, 8'h00};
    tbl[5] = '{1, 1, 8'h50, 1, 1, 9'h005, 1, 16'h3040, 8'h01};
    tbl[6] = '{1, 1, 8'h60, 1, 1, 9'h006, 0, 16'h0000, 8'h00};
    tbl[7] = '{1, 1, 8'h70, 1, 1, 9'h007, 1, 16'h5060, 8'h02};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_gnt = tbl[i].gnt; mem_rvalid = tbl[i].rvalid; mem_rdata = tbl[i].rdata;
      instr_ready = tbl[i].ready; redirect_valid = 1'b0;
      #1;
      check($sformatf("t%0d_req", i), 32'(mem_req), 32'(tbl[i].req));
      check($sformatf("t%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
      check($sformatf("t%0d_valid", i), 32'(instr_valid), 32'(tbl[i].iv));
      check($sformatf("t%0d_data", i), 32'(instr_data), 32'(tbl[i].id));
      check($sformatf("t%0d_pc", i), 32'(instr_pc), 32'(tbl[i].ipc));
      @(posedge clk);
    end

    // Backpressure: exactly DEPTH instructions buffered, then drained in order.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 8'h00, 1, 1);
    check("bp_req_dropped", 32'(s_req), 0);
    check("bp_valid", 32'(s_iv), 1);
    check("bp_grants", 32'(grants), 2 * DEPTH);
    for (int i = 0; i < 14; i++) cycle(1, 1, 0, 8'h00, 1, 1);
    check("bp_drained", 32'(acc_pc.size() >= 5), 1);
    for (int i = 0; i < 5 && i < acc_pc.size(); i++) check($sformatf("bp_order%0d", i), 32'(acc_pc[i]), i);

    // Redirect with two reads in flight: both dropped, next instruction from pc 0x80.
    do_reset();
    cycle(1, 0, 0, 8'h00, 3, 3);
    cycle(1, 0, 0, 8'h00, 3, 3);
    cycle(1, 0, 1, 8'h80, 3, 3);
    cycle(1, 1, 0, 8'h00, 1, 1);
    check("redir_empty", 32'(s_iv), 0);
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, 8'h00, 1, 1);
    check("redir_delivered", 32'(acc_pc.size() > 0), 1);
    if (acc_pc.size() > 0) check("redir_first_pc", 32'(acc_pc[0]), 32'h80);

    // Wrap: fetch address 0x1FF rolls to 0x000.
    do_reset();
    cycle(1, 1, 1, 8'hFF, 1, 1);
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, 8'h00, 1, 1);
    check("wrap_count", 32'(acc_pc.size() >= 2), 1);
    if (acc_pc.size() >= 2) begin
      check("wrap_pc0", 32'(acc_pc[0]), 32'hFF);
      check("wrap_pc1", 32'(acc_pc[1]), 32'h00);
    end

    // Stalled grant: request and address held for 5 cycles.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 8'h00, 1, 1);
      check("stall_hold_req", 32'(s_req), 1);
      check("stall_hold_addr", 32'(s_addr), 0);
    end
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 8'h00, 1, 1);
    check("stall_resume", 32'(acc_pc.size() > 0), 1);

    // Reset mid-fetch with two buffered entries.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'h00, 1, 1);
    @(negedge clk); #1;
    check("midrst_pre_valid", 32'(instr_valid), 1);
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(instr_valid), 0);
    check("midrst_req", 32'(mem_req), 0);
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 8'h00, 1, 1);
    check("midrst_restart", 32'(acc_pc.size() > 0), 1);
    if (acc_pc.size() > 0) check("midrst_first_pc", 32'(acc_pc[0]), 0);

`ifdef PREFETCH_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 8'(i * 7), 1, 1);
    #1;
    check("flush_count3", 32'(flush_count), 3);
    do_reset();
`endif

    // Random traffic against the stream model.
    do_reset();
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
            8'($urandom), 1, 3);
    check("rand_progress", 32'(acc_pc.size() > 100), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
